// File: rtl/game_pkg.sv
// Shared screen geometry, colour type and scheduler state encoding.
package game_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COL_W    = 3;

    // Raster counter covers 0..15; dimensions need one more bit for the value 16.
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DIM_W    = 5;

    typedef logic [COL_W-1:0] colour_t;

    localparam colour_t COLOUR_BLACK = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Requester bus plus VGA adapter plot port of the sprite draw scheduler.
interface sprite_draw_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    import game_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*X_W-1:0]   req_x;
    logic [NUM_REQ*Y_W-1:0]   req_y;
    logic [NUM_REQ*COL_W-1:0] req_colour;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [X_W-1:0]           vga_x;
    logic [Y_W-1:0]           vga_y;
    colour_t                  vga_colour;
    logic                     vga_plot;

    // Requester / game-logic side
    modport master (
        output req, req_x, req_y, req_colour,
        input  grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    // Scheduler side
    modport slave (
        input  req, req_x, req_y, req_colour,
        output grant, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/sprite_draw_scheduler_raster.sv
// rect_raster: column-inner / row-outer counter over a width x height rectangle.
// col/row/last describe the pixel that follows the one currently being emitted.
module rect_raster
    import game_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [DIM_W-1:0] width,
    input  logic [DIM_W-1:0] height,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             last
);

    logic [CNT_W-1:0] col_q;
    logic [CNT_W-1:0] row_q;
    logic             col_end;

    // Successor coordinate and whether it closes the rectangle
    always_comb begin
        col_end = (DIM_W'(col_q) == width - DIM_W'(1));
        col     = col_end ? '0 : col_q + CNT_W'(1);
        row     = col_end ? row_q + CNT_W'(1) : row_q;
        last    = (DIM_W'(col) == width - DIM_W'(1)) && (DIM_W'(row) == height - DIM_W'(1));
    end

    // Position of the pixel on the output; start marks pixel (0,0) as emitted
    always_ff @(posedge CLOCK_50) begin
        if (reset || start) begin
            col_q <= '0;
            row_q <= '0;
        end else if (step) begin
            col_q <= col;
            row_q <= row;
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-robin sprite scheduler driving the single VGA adapter plot port.
// Optional feature macro DRAW_ERASE_EN: erase each requester's previous
// rectangle in black before drawing its new one.
module sprite_draw_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned SPRITE_W = 16,
    parameter int unsigned SPRITE_H = 16
)(
    input  logic                   CLOCK_50,
    input  logic                   reset,
    sprite_draw_scheduler_if.slave bus
);

    localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic        ONE_PIXEL = (SPRITE_W == 1) && (SPRITE_H == 1);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d, win_q, win_d;
    logic [X_W-1:0]     ox_q, ox_d;
    logic [Y_W-1:0]     oy_q, oy_d;
    colour_t            colour_q, colour_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic               busy_q, busy_d, plot_q, plot_d;
    logic [X_W-1:0]     vga_x_q, vga_x_d;
    logic [Y_W-1:0]     vga_y_q, vga_y_d;
    colour_t            vga_colour_q, vga_colour_d;

`ifdef DRAW_ERASE_EN
    logic [X_W-1:0]     prev_x_q [NUM_REQ];
    logic [X_W-1:0]     prev_x_d [NUM_REQ];
    logic [Y_W-1:0]     prev_y_q [NUM_REQ];
    logic [Y_W-1:0]     prev_y_d [NUM_REQ];
    logic [NUM_REQ-1:0] prev_v_q, prev_v_d;
`endif

    logic               arb_found;
    logic [PTR_W-1:0]   arb_win, arb_idx;
    logic               raster_start, raster_step, raster_last;
    logic [CNT_W-1:0]   raster_col, raster_row;
    logic               px_en, px_last;
    logic [X_W-1:0]     px_x0;
    logic [Y_W-1:0]     px_y0;
    colour_t            px_colour;
    logic [CNT_W-1:0]   px_col, px_row;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;

    rect_raster u_raster (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (raster_start),
        .step     (raster_step),
        .width    (DIM_W'(SPRITE_W)),
        .height   (DIM_W'(SPRITE_H)),
        .col      (raster_col),
        .row      (raster_row),
        .last     (raster_last)
    );

    // Round-robin search upward from the pointer, wrapping
    always_comb begin
        arb_found = 1'b0;
        arb_win   = ptr_q;
        arb_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            arb_idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!arb_found && bus.req[arb_idx]) begin
                arb_found = 1'b1;
                arb_win   = arb_idx;
            end
        end
    end

    // Next state, job capture and next pixel
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        colour_d     = colour_q;
        last_d       = last_q;
        grant_d      = '0;
        done_d       = '0;
        busy_d       = busy_q;
        plot_d       = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        raster_start = 1'b0;
        raster_step  = 1'b0;
        px_en        = 1'b0;
        px_x0        = ox_q;
        px_y0        = oy_q;
        px_colour    = colour_q;
        px_col       = raster_col;
        px_row       = raster_row;
        px_last      = raster_last;
        sum_x        = '0;
        sum_y        = '0;
`ifdef DRAW_ERASE_EN
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        prev_v_d     = prev_v_q;
`endif

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (arb_found) begin
                    grant_d      = NUM_REQ'(1) << arb_win;
                    win_d        = arb_win;
                    ptr_d        = PTR_W'((32'(arb_win) + 32'd1) % NUM_REQ);
                    ox_d         = bus.req_x[X_W*32'(arb_win) +: X_W];
                    oy_d         = bus.req_y[Y_W*32'(arb_win) +: Y_W];
                    colour_d     = bus.req_colour[COL_W*32'(arb_win) +: COL_W];
                    busy_d       = 1'b1;
                    raster_start = 1'b1;
                    px_en        = 1'b1;
                    px_col       = '0;
                    px_row       = '0;
                    px_last      = ONE_PIXEL;
                    px_x0        = ox_d;
                    px_y0        = oy_d;
                    px_colour    = colour_d;
                    state_d      = ST_DRAW;
`ifdef DRAW_ERASE_EN
                    if (prev_v_q[arb_win]) begin
                        state_d   = ST_ERASE;
                        px_x0     = prev_x_q[arb_win];
                        px_y0     = prev_y_q[arb_win];
                        px_colour = COLOUR_BLACK;
                    end
`endif
                end
            end
`ifdef DRAW_ERASE_EN
            ST_ERASE: begin
                px_en = 1'b1;
                if (last_q) begin
                    state_d      = ST_DRAW;
                    raster_start = 1'b1;
                    px_col       = '0;
                    px_row       = '0;
                    px_last      = ONE_PIXEL;
                end else begin
                    raster_step = 1'b1;
                    px_x0       = prev_x_q[win_q];
                    px_y0       = prev_y_q[win_q];
                    px_colour   = COLOUR_BLACK;
                end
            end
`endif
            ST_DRAW: begin
                if (last_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
`ifdef DRAW_ERASE_EN
                    prev_x_d[win_q] = ox_q;
                    prev_y_d[win_q] = oy_q;
                    prev_v_d[win_q] = 1'b1;
`endif
                end else begin
                    raster_step = 1'b1;
                    px_en       = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Shared pixel stage: clip, plot, and flag the job's final pixel
        if (px_en) begin
            last_d = px_last;
            if (state_d == ST_DRAW && px_last) begin
                done_d = NUM_REQ'(1) << win_d;
            end
            sum_x = (X_W+1)'(px_x0) + (X_W+1)'(px_col);
            sum_y = (Y_W+1)'(px_y0) + (Y_W+1)'(px_row);
            if (sum_x < (X_W+1)'(SCREEN_W) && sum_y < (Y_W+1)'(SCREEN_H)) begin
                plot_d       = 1'b1;
                vga_x_d      = sum_x[X_W-1:0];
                vga_y_d      = sum_y[Y_W-1:0];
                vga_colour_d = px_colour;
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            win_q        <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            colour_q     <= '0;
            last_q       <= 1'b0;
            grant_q      <= '0;
            done_q       <= '0;
            busy_q       <= 1'b0;
            plot_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
`ifdef DRAW_ERASE_EN
            prev_x_q     <= '{default: '0};
            prev_y_q     <= '{default: '0};
            prev_v_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            colour_q     <= colour_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            plot_q       <= plot_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
`ifdef DRAW_ERASE_EN
            prev_x_q     <= prev_x_d;
            prev_y_q     <= prev_y_d;
            prev_v_q     <= prev_v_d;
`endif
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = plot_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: stimulus queues expected jobs and
// pixels, a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_sprite_draw_scheduler;
    import game_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SW      = 16;
    localparam int unsigned SH      = 16;

    typedef struct {
        logic [NUM_REQ-1:0] grant;
        int                 plots;
        int                 done_off;
        int                 gap;
    } job_t;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #10 CLOCK_50 = ~CLOCK_50;

    sprite_draw_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    sprite_draw_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .SPRITE_W (SW),
        .SPRITE_H (SH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [17:0] pix_q[$];
    job_t        job_q[$];

`ifdef DRAW_ERASE_EN
    int m_px[NUM_REQ];
    int m_py[NUM_REQ];
    bit m_pv[NUM_REQ];
`endif

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference raster with clipping; budget limits the number of raster cycles modelled
    function automatic void gen_rect(input int x0, input int y0, input int c,
                                     inout int budget, inout int plots);
        for (int r = 0; r < int'(SH); r++) begin
            for (int k = 0; k < int'(SW); k++) begin
                if (budget > 0) begin
                    budget--;
                    if (x0 + k < 160 && y0 + r < 120) begin
                        pix_q.push_back({8'(x0 + k), 7'(y0 + r), 3'(c)});
                        plots++;
                    end
                end
            end
        end
    endfunction

    // Queue one job; limit>0 models a job cut off by reset after that many raster cycles
    function automatic void push_job(input int r, input int x, input int y, input int c,
                                     input int gap, input int limit);
        job_t j;
        int budget = (limit > 0) ? limit : 32'h3fff_ffff;
        int plots  = 0;
        int cycles = int'(SW * SH);
        j.grant = NUM_REQ'(1) << r;
`ifdef DRAW_ERASE_EN
        if (m_pv[r]) begin
            gen_rect(m_px[r], m_py[r], 0, budget, plots);
            cycles += int'(SW * SH);
        end
        if (limit == 0) begin
            m_px[r] = x;
            m_py[r] = y;
            m_pv[r] = 1'b1;
        end
`endif
        gen_rect(x, y, c, budget, plots);
        j.plots    = plots;
        j.done_off = (limit > 0) ? -1 : cycles - 1;
        j.gap      = gap;
        job_q.push_back(j);
    endfunction

    function automatic void model_reset();
`ifdef DRAW_ERASE_EN
        for (int i = 0; i < int'(NUM_REQ); i++) m_pv[i] = 1'b0;
`endif
    endfunction

    // Monitor
    job_t cur;
    bit   cur_v     = 1'b0;
    bit   chk_idle  = 1'b0;
    int   grant_cyc = 0;
    int   done_cyc  = -1000;
    int   plot_cnt  = 0;

    always @(negedge CLOCK_50) begin
        if (chk_idle) begin
            chk("busy_after_done", int'(bus.busy), 0);
            chk_idle = 1'b0;
        end
        if (bus.grant != '0) begin
            if (job_q.size() == 0) begin
                chk("grant_unexpected", int'(bus.grant), 0);
            end else begin
                cur   = job_q.pop_front();
                cur_v = 1'b1;
                chk("grant", int'(bus.grant), int'(cur.grant));
                if (cur.gap >= 0) chk("job_gap", cyc - done_cyc, cur.gap);
            end
            grant_cyc = cyc;
            plot_cnt  = 0;
        end
        if (bus.vga_plot) begin
            plot_cnt++;
            chk("busy_while_plot", int'(bus.busy), 1);
            if (pix_q.size() == 0)
                chk("pixel_unexpected", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), -1);
            else
                chk("pixel", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), int'(pix_q.pop_front()));
        end
        if (bus.done != '0) begin
            if (!cur_v || cur.done_off < 0) begin
                chk("done_unexpected", int'(bus.done), 0);
            end else begin
                chk("done_who", int'(bus.done), int'(cur.grant));
                chk("done_cycle", cyc - grant_cyc, cur.done_off);
                chk("job_plots", plot_cnt, cur.plots);
            end
            cur_v    = 1'b0;
            done_cyc = cyc;
            chk_idle = 1'b1;
        end
        if (reset) cur_v = 1'b0;
    end

    // Stimulus helpers
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_src(input int r, input int x, input int y, input int c);
        bus.req_x[r*8 +: 8]      = 8'(x);
        bus.req_y[r*7 +: 7]      = 7'(y);
        bus.req_colour[r*3 +: 3] = 3'(c);
    endtask

    task automatic wait_grant(output logic [NUM_REQ-1:0] g);
        g = '0;
        for (int n = 0; n < 2000; n++) begin
            step();
            if (bus.grant != '0) begin
                g = bus.grant;
                return;
            end
        end
        chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 0, 1);
        repeat (2) step();
    endtask

    task automatic serve(input logic [NUM_REQ-1:0] mask);
        logic [NUM_REQ-1:0] g;
        bus.req = mask;
        while (bus.req != '0) begin
            wait_grant(g);
            if (g == '0) break;
            bus.req = bus.req & ~g;
        end
        bus.req = '0;
        wait_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        model_reset();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ-1:0] g;
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        model_reset();
        do_reset();

        // Reset state
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_done",  int'(bus.done), 0);
        chk("rst_busy",  int'(bus.busy), 0);
        chk("rst_plot",  int'(bus.vga_plot), 0);
        chk("rst_vga",   int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);

        // 1: single job, grant one cycle after request
        set_src(0, 80, 50, 2);
        push_job(0, 80, 50, 2, -1, 0);
        bus.req = 4'b0001;
        step();
        chk("t1_grant_latency", int'(bus.grant), 1);
        bus.req = '0;
        wait_idle();

        // 2: all four requesters at once from pointer 0
        do_reset();
        set_src(0, 10, 10, 1);
        set_src(1, 30, 10, 2);
        set_src(2, 50, 10, 3);
        set_src(3, 70, 10, 4);
        push_job(0, 10, 10, 1, -1, 0);
        push_job(1, 30, 10, 2, 2, 0);
        push_job(2, 50, 10, 3, 2, 0);
        push_job(3, 70, 10, 4, 2, 0);
        serve(4'b1111);

        // 3: req[0] held, req[2] rises mid-job and wins before req[0] again
        set_src(0, 5, 60, 5);
        set_src(2, 100, 20, 6);
        push_job(0, 5, 60, 5, -1, 0);
        push_job(2, 100, 20, 6, 2, 0);
        push_job(0, 5, 60, 5, 2, 0);
        bus.req = 4'b0001;
        wait_grant(g);
        chk("t3_first", int'(g), 1);
        repeat (10) step();
        bus.req[2] = 1'b1;
        wait_grant(g);
        chk("t3_second", int'(g), 4);
        bus.req[2] = 1'b0;
        wait_grant(g);
        chk("t3_third", int'(g), 1);
        bus.req = '0;
        wait_idle();

        // 4: clipped corner rectangle
        set_src(1, 150, 110, 5);
        push_job(1, 150, 110, 5, -1, 0);
        serve(4'b0010);

        // 5: reset at pixel 40 aborts the job; pointer search restarts at 0
        set_src(2, 20, 30, 6);
        push_job(2, 20, 30, 6, -1, 40);
        bus.req = 4'b0100;
        wait_grant(g);
        bus.req = '0;
        chk("t5_grant", int'(g), 4);
        repeat (39) step();
        reset = 1'b1;
        step();
        chk("t5_plot",  int'(bus.vga_plot), 0);
        chk("t5_busy",  int'(bus.busy), 0);
        chk("t5_done",  int'(bus.done), 0);
        chk("t5_grant_clr", int'(bus.grant), 0);
        reset = 1'b0;
        model_reset();
        step();
        set_src(1, 0, 0, 7);
        set_src(3, 40, 100, 1);
        push_job(1, 0, 0, 7, -1, 0);
        push_job(3, 40, 100, 1, 2, 0);
        serve(4'b1010);

        // 6: same requester moved by one pixel (erase pass when enabled)
        set_src(0, 80, 50, 2);
        push_job(0, 80, 50, 2, -1, 0);
        serve(4'b0001);
        set_src(0, 81, 50, 3);
        push_job(0, 81, 50, 3, -1, 0);
        serve(4'b0001);

        repeat (4) step();
        chk("pix_q_empty", pix_q.size(), 0);
        chk("job_q_empty", job_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
